// File: rtl/led_pkg.sv
// led_pkg: mode/phase encodings and the start-pattern helper shared by the LED mode processors.
package led_pkg;
  typedef enum logic [1:0] {
    MODE_DRAIN  = 2'd0,
    MODE_FILL   = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;
  typedef enum logic {
    PH_RUN  = 1'b0,
    PH_HOLD = 1'b1
  } phase_t;
  // Returned in 32 bits; the caller truncates to its own LED count n.
  function automatic logic [31:0] start_pattern(mode_t m, logic d, int n);
    return m == MODE_DRAIN ? (n >= 32 ? 32'hFFFF_FFFF : (32'd1 << n) - 32'd1)
         : m == MODE_FILL  ? 32'd0
         : d               ? 32'd1 << (n - 1) : 32'd1;
  endfunction
endpackage

// File: rtl/led_pattern_next.sv
// led_pattern_next: next LED pattern and step for an ordinary RUN-phase advance.
module led_pattern_next
  import led_pkg::*;
#(
  parameter int N_LEDS = 8,
  parameter int STEP_W = 4
) (
  input  mode_t             mode,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic [N_LEDS-1:0] leds,
  output logic [N_LEDS-1:0] next_leds,
  output logic [STEP_W-1:0] next_step
);
  localparam logic [STEP_W-1:0] LAST = STEP_W'(N_LEDS - 1);
  localparam logic [STEP_W-1:0] TURN = STEP_W'(2 * N_LEDS - 3);
  logic [STEP_W-1:0] pos, idx;
  logic [N_LEDS-1:0] bit_sel;
  // BOUNCE folds the step back once it passes the far end, so each end lights once.
  always_comb begin
    next_step = step + STEP_W'(1);
    pos = (mode == MODE_DRAIN || mode == MODE_FILL) ? step
        : (mode == MODE_BOUNCE && next_step > LAST) ? TURN - step : next_step;
    idx = dir ? LAST - pos : pos;
    bit_sel = {{(N_LEDS-1){1'b0}}, 1'b1} << idx;
    next_leds = mode == MODE_DRAIN ? leds & ~bit_sel
              : mode == MODE_FILL  ? leds | bit_sel : bit_sel;
  end
endmodule

// File: rtl/led_sweep_engine.sv
// led_sweep_engine: tick-driven LED sequencer (DRAIN/FILL/CHASE/BOUNCE) with hold, pause and restart.
module led_sweep_engine
  import led_pkg::*;
#(
  parameter int N_LEDS     = 8,
  parameter int HOLD_TICKS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              pause,
  input  logic              restart,
  input  logic [1:0]        mode,
  input  logic              dir,
  output logic [N_LEDS-1:0] leds,
  output logic [1:0]        active_mode,
  output logic              cycle_done
);
  // Step counter must reach 2*N_LEDS-3 for BOUNCE.
  localparam int STEP_W = $clog2(2 * N_LEDS);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  mode_t             am;
  logic              ad;
  phase_t            ph;
  logic [STEP_W-1:0] step, nxt_step;
  logic [HOLD_W-1:0] hold;
  logic [N_LEDS-1:0] nxt_leds;
  logic              adv, is_df, boundary, start;
  led_pattern_next #(.N_LEDS(N_LEDS), .STEP_W(STEP_W)) u_next (
    .mode      (am),
    .dir       (ad),
    .step      (step),
    .leds      (leds),
    .next_leds (nxt_leds),
    .next_step (nxt_step)
  );
  always_comb begin
    adv = tick & ~pause;
    is_df = am == MODE_DRAIN || am == MODE_FILL;
    boundary = is_df ? (ph == PH_HOLD && hold == HOLD_W'(HOLD_TICKS - 1))
             : am == MODE_CHASE ? step == STEP_W'(N_LEDS - 1)
             : step == STEP_W'(2 * N_LEDS - 3);
    start = restart | (adv & boundary);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds       <= '1;
      am         <= MODE_DRAIN;
      ad         <= 1'b0;
      step       <= '0;
      hold       <= '0;
      ph         <= PH_RUN;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= start;
      if (start) begin
        leds <= N_LEDS'(start_pattern(mode_t'(mode), dir, N_LEDS));
        am   <= mode_t'(mode);
        ad   <= dir;
        step <= '0;
        ph   <= PH_RUN;
      end else if (adv) begin
        if (ph == PH_HOLD) begin
          hold <= hold + HOLD_W'(1);
        end else if (is_df && step == STEP_W'(N_LEDS)) begin
          ph   <= PH_HOLD;
          hold <= '0;
          leds <= N_LEDS'(start_pattern(am, ad, N_LEDS));
        end else begin
          leds <= nxt_leds;
          step <= nxt_step;
        end
      end
    end
  end
  assign active_mode = am;
endmodule
